// File: rtl/spi_slave_gen.sv
// spi_slave_gen: parametrised SPI slave that deserialises command frames and serialises read data
// Ports: clk, rst (async, active-high)
//        SS_n, MOSI, MISO      - serial link, SS_n low frames a transfer
//        tx_valid, tx_data     - read data offered by the back end
//        rx_valid, rx_data     - one-cycle pulse with received {opcode, data}
//        have_addr             - read address received, read data still pending
//        busy, frame_err       - FSM active; pulse on abort or tx_valid timeout
module spi_slave_gen #(
    parameter int DATA_W     = 8,
    parameter bit LSB_FIRST  = 0,
    parameter int TX_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              MISO,
    output logic              rx_valid,
    output logic [DATA_W+1:0] rx_data,
    output logic              have_addr,
    output logic              busy,
    output logic              frame_err
);
    localparam int RW = DATA_W + 2;
    localparam int CW = $clog2(RW) + 1;
    localparam int TW = $clog2(TX_TIMEOUT + 1) + 1;
    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT, DONE} state_t;
    state_t            state;
    logic [RW-1:0]     rx_sr;
    logic [DATA_W-1:0] tx_sr;
    logic [CW-1:0]     cnt;
    logic [TW-1:0]     tcnt;
    logic [RW-1:0]     rx_next;
    logic [DATA_W-1:0] ld_next;
    logic [DATA_W-1:0] sh_next;
    logic              ld_bit;
    logic              sh_bit;
    logic              rx_last;
    logic              tx_last;
    logic              timed_out;
    assign rx_next   = LSB_FIRST ? {MOSI, rx_sr[RW-1:1]} : {rx_sr[RW-2:0], MOSI};
    assign ld_bit    = LSB_FIRST ? tx_data[0] : tx_data[DATA_W-1];
    assign ld_next   = LSB_FIRST ? tx_data >> 1 : tx_data << 1;
    assign sh_bit    = LSB_FIRST ? tx_sr[0] : tx_sr[DATA_W-1];
    assign sh_next   = LSB_FIRST ? tx_sr >> 1 : tx_sr << 1;
    assign rx_last   = cnt == CW'(RW - 1);
    assign tx_last   = cnt == CW'(DATA_W);
    // TX_TIMEOUT = 0 disables the timeout entirely
    assign timed_out = (TX_TIMEOUT > 0) && (tcnt == TW'(TX_TIMEOUT - 1));
    assign busy      = state != IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            MISO      <= 1'b0;
            rx_valid  <= 1'b0;
            rx_data   <= '0;
            have_addr <= 1'b0;
            frame_err <= 1'b0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            cnt       <= '0;
            tcnt      <= '0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (state != IDLE && SS_n) begin
                // frame end; only a rise outside DONE is an abort
                state     <= IDLE;
                frame_err <= state != DONE;
                MISO      <= 1'b0;
                rx_sr     <= '0;
                cnt       <= '0;
                tcnt      <= '0;
            end else begin
                case (state)
                    IDLE: if (!SS_n) state <= CHK_CMD;
                    CHK_CMD: state <= !MOSI ? WRITE : have_addr ? READ_DATA : READ_ADD;
                    WRITE, READ_ADD, READ_DATA: begin
                        rx_sr <= rx_next;
                        cnt   <= cnt + 1'b1;
                        if (rx_last) begin
                            rx_data  <= rx_next;
                            rx_valid <= 1'b1;
                            cnt      <= '0;
                            if (state == READ_ADD) have_addr <= 1'b1;
                            state <= state == READ_DATA ? TX_WAIT : DONE;
                        end
                    end
                    TX_WAIT: begin
                        if (tx_valid) begin
                            // first bit goes out straight from tx_data so it appears the cycle after capture
                            MISO  <= ld_bit;
                            tx_sr <= ld_next;
                            cnt   <= CW'(1);
                            tcnt  <= '0;
                            state <= TX_SHIFT;
                        end else if (timed_out) begin
                            frame_err <= 1'b1;
                            tcnt      <= '0;
                            state     <= DONE;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    TX_SHIFT: begin
                        if (tx_last) begin
                            MISO      <= 1'b0;
                            have_addr <= 1'b0;
                            cnt       <= '0;
                            state     <= DONE;
                        end else begin
                            MISO  <= sh_bit;
                            tx_sr <= sh_next;
                            cnt   <= cnt + 1'b1;
                        end
                    end
                    default: MISO <= 1'b0;
                endcase
            end
        end
    end
endmodule
